// File: rtl/alu_seq_pkg.sv
// Shared encodings for the slice-serial ALU: opcodes, flag policy, flag bit
// positions, FSM states and the per-slice operation class.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_CP  = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8;
  localparam logic [3:0] OP_DEC = 4'd9;
  // Internal marker for any opcode outside the legal set
  localparam logic [3:0] OP_ILL = 4'hF;

  localparam logic [1:0] ZM_CALC = 2'd0;
  localparam logic [1:0] ZM_KEEP = 2'd1;
  localparam logic [1:0] ZM_CLR  = 2'd2;
  localparam logic [1:0] ZM_ALL  = 2'd3;

  localparam int F_Z = 3;
  localparam int F_N = 2;
  localparam int F_H = 1;
  localparam int F_C = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    K_ADD = 3'd0,
    K_SUB = 3'd1,
    K_AND = 3'd2,
    K_OR  = 3'd3,
    K_XOR = 3'd4
  } kind_t;

  function automatic kind_t op_kind(input logic [3:0] op);
    kind_t k;
    k = K_ADD;
    case (op)
      OP_SUB, OP_SBC, OP_CP, OP_DEC: k = K_SUB;
      OP_AND:                        k = K_AND;
      OP_OR:                         k = K_OR;
      OP_XOR:                        k = K_XOR;
      default:                       k = K_ADD;
    endcase
    return k;
  endfunction

  function automatic logic init_carry(input logic [3:0] op, input logic c_in);
    logic c;
    c = 1'b0;
    case (op)
      OP_ADC, OP_SBC: c = c_in;
      OP_INC, OP_DEC: c = 1'b1;
      default:        c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE_W-bit add/sub/logic cell; for subtraction cin/cout are
// borrows, so the chain works for multi-slice differences without recoding.
module alu_slice
  import alu_seq_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  kind_t              kind,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] y,
  output logic               cout
);

  logic [SLICE_W:0] sum;
  logic [SLICE_W:0] dif;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
    // Top bit of the widened difference is set exactly when a - b - cin < 0
    dif  = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, cin};
    y    = sum[SLICE_W-1:0];
    cout = 1'b0;
    unique case (kind)
      K_ADD: begin
        y    = sum[SLICE_W-1:0];
        cout = sum[SLICE_W];
      end
      K_SUB: begin
        y    = dif[SLICE_W-1:0];
        cout = dif[SLICE_W];
      end
      K_AND: y = a & b;
      K_OR:  y = a | b;
      K_XOR: y = a ^ b;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Slice-serial ALU with ZNHC flags: one SLICE_W-bit slice per clock, LSB first,
// valid/ready on both sides. One alu_slice is reused every RUN cycle.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SLICE_W = 4,
  parameter int OP_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [1:0]        zmode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        flags_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags_out
);

  localparam int N     = DATA_W / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  // Slice whose carry-out is the carry into the top nibble
  localparam int H_IDX = (DATA_W - 4) / SLICE_W - 1;

  state_t                    state, state_nx;
  logic [IDX_W-1:0]          idx;
  logic [3:0]                op_c, op_q;
  logic [1:0]                zm_q;
  logic [3:0]                fl_q;
  logic [DATA_W-1:0]         a_sh, b_sh;
  logic [DATA_W-SLICE_W-1:0] r_sh;
  logic                      carry, h_q, z_acc;

  kind_t                     kind;
  logic [SLICE_W-1:0]        y;
  logic                      cout, last, h_fin, z_fin, arith;
  logic [DATA_W-1:0]         a_nx, r_nx, res_fin;
  logic [3:0]                fl_fin;

  assign op_c      = (op <= OP_W'(OP_DEC)) ? 4'(op) : OP_ILL;
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  alu_slice #(.SLICE_W(SLICE_W)) u_slice (
    .kind (kind),
    .a    (a_sh[SLICE_W-1:0]),
    .b    (b_sh[SLICE_W-1:0]),
    .cin  (carry),
    .y    (y),
    .cout (cout)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (in_valid)  state_nx = S_RUN;
      S_RUN:   if (last)      state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    kind  = op_kind(op_q);
    arith = (kind == K_ADD) || (kind == K_SUB);
    last  = (idx == IDX_W'(N - 1));
    // a rotates rather than shifts so it is whole again after N slices (CP/illegal)
    a_nx  = {a_sh[SLICE_W-1:0], a_sh[DATA_W-1:SLICE_W]};
    r_nx  = {y, r_sh};
    h_fin = (idx == IDX_W'(H_IDX)) ? cout : h_q;
    z_fin = z_acc & ~|y;

    res_fin      = r_nx;
    fl_fin       = '0;
    fl_fin[F_Z]  = z_fin;
    fl_fin[F_N]  = (kind == K_SUB);
    fl_fin[F_H]  = arith ? h_fin : (kind == K_AND);
    fl_fin[F_C]  = arith ? cout : 1'b0;
    if (op_q == OP_INC || op_q == OP_DEC) fl_fin[F_C] = fl_q[F_C];
    if (op_q == OP_CP) res_fin = a_nx;
    case (zm_q)
      ZM_KEEP: fl_fin[F_Z] = fl_q[F_Z];
      ZM_CLR:  fl_fin[F_Z] = 1'b0;
      ZM_ALL:  fl_fin      = fl_q;
      default: ;
    endcase
    if (op_q == OP_ILL) begin
      res_fin = a_nx;
      fl_fin  = fl_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      op_q      <= '0;
      zm_q      <= '0;
      fl_q      <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      carry     <= 1'b0;
      h_q       <= 1'b0;
      z_acc     <= 1'b0;
      result    <= '0;
      flags_out <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: if (in_valid) begin
          op_q  <= op_c;
          zm_q  <= zmode;
          fl_q  <= flags_in;
          a_sh  <= a;
          b_sh  <= (op_c == OP_INC || op_c == OP_DEC) ? '0 : b;
          idx   <= '0;
          carry <= init_carry(op_c, flags_in[F_C]);
          h_q   <= 1'b0;
          z_acc <= 1'b1;
          r_sh  <= '0;
        end
        S_RUN: begin
          a_sh  <= a_nx;
          b_sh  <= b_sh >> SLICE_W;
          r_sh  <= r_nx[DATA_W-1:SLICE_W];
          carry <= cout;
          z_acc <= z_fin;
          h_q   <= h_fin;
          idx   <= idx + 1'b1;
          if (last) begin
            result    <= res_fin;
            flags_out <= fl_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
